// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller receiver: FSM states, button bit
// positions and the serial frame length.
package nes_pkg;

  localparam int NES_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    DONE   = 3'd4
  } nes_state_e;

endpackage

// File: rtl/nes_input_sync.sv
// Two-flop synchroniser for an asynchronous input pin; resets to 1 (released).
module nes_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Metastability filter: shift the raw pin through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/nes_controller_rx.sv
// NES controller serial receiver: latch, clock out eight bits, present buttons.
// Optional build macro NES_RX_DEBOUNCE_EN: require two identical reads to update.
module nes_controller_rx
  import nes_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 151
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                nes_data,
  output logic                nes_latch,
  output logic                nes_clk,
  output logic [NES_BITS-1:0] buttons,
  output logic                valid,
  output logic                busy
);

  localparam int CNT_W = $clog2(2 * HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(2 * HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_PERIOD - 1);

  nes_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [NES_BITS-1:0] shift_q, shift_d;
  logic [NES_BITS-1:0] buttons_q, buttons_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                latch_q, latch_d;
  logic                nclk_q, nclk_d;
  logic                data_sync;
  logic                expired;
`ifdef NES_RX_DEBOUNCE_EN
  logic [NES_BITS-1:0] shadow_q, shadow_d;
`endif

  nes_input_sync u_data_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (nes_data),
    .q_o   (data_sync)
  );

  assign expired = (cnt_q == '0);

  // Next-state, phase timer and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = expired ? cnt_q : cnt_q - CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    latch_d   = latch_q;
    nclk_d    = nclk_q;
`ifdef NES_RX_DEBOUNCE_EN
    shadow_d  = shadow_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LATCH;
          cnt_d   = CNT_LATCH;
          latch_d = 1'b1;
        end else begin
          latch_d = 1'b0;
        end
      end
      LATCH: begin
        if (expired) begin
          latch_d = 1'b0;
          state_d = CLK_LO;
          cnt_d   = CNT_HALF;
          idx_d   = 3'd0;
        end else begin
          latch_d = 1'b1;
        end
      end
      CLK_LO: begin
        if (expired) begin
          // Line is active low; store as 1 = pressed.
          shift_d[idx_q] = ~data_sync;
          nclk_d         = 1'b1;
          state_d        = CLK_HI;
          cnt_d          = CNT_HALF;
        end else begin
          nclk_d = 1'b0;
        end
      end
      CLK_HI: begin
        if (expired) begin
          nclk_d = 1'b0;
          cnt_d  = CNT_HALF;
          if (idx_q == 3'd7) begin
            // Update buttons on entry so they appear together with valid.
            state_d = DONE;
            valid_d = 1'b1;
`ifdef NES_RX_DEBOUNCE_EN
            if (shift_q == shadow_q) begin
              buttons_d = shift_q;
            end else begin
              buttons_d = buttons_q;
            end
            shadow_d = shift_q;
`else
            buttons_d = shift_q;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = CLK_LO;
          end
        end else begin
          nclk_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        latch_d = 1'b0;
        nclk_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      buttons_q <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
    end
  end

`ifdef NES_RX_DEBOUNCE_EN
  // Previous raw read for the two-read agreement filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= 8'h00;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign nes_latch = latch_q;
  assign nes_clk   = nclk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nes_controller_rx.sv
// Directed bench for nes_controller_rx with a behavioural 4021-style controller.
module tb_nes_controller_rx;

  localparam int H = 4;
`ifdef NES_RX_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_clk, valid, busy;
  logic [7:0] buttons;

  int checks = 0;
  int passed = 0;

  logic [7:0] pressed_r = 8'h00;
  logic [7:0] ctl_sr = 8'hFF;
  logic       ctl_prev = 1'b0;

  int lat_cnt = 0;
  int rise_cnt = 0;
  int val_cnt = 0;
  logic mon_prev = 1'b0;

  nes_controller_rx #(.HALF_PERIOD(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_clk   (nes_clk),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Controller: parallel load while latched, shift on each clock rise.
  always @(posedge clk) begin
    if (nes_latch) ctl_sr <= ~pressed_r;
    else if (nes_clk && !ctl_prev) ctl_sr <= {1'b1, ctl_sr[7:1]};
    ctl_prev <= nes_clk;
  end
  assign nes_data = ctl_sr[0];

  // Cumulative line activity counters.
  always @(negedge clk) begin
    if (nes_latch) lat_cnt <= lat_cnt + 1;
    if (nes_clk && !mon_prev) rise_cnt <= rise_cnt + 1;
    if (valid) val_cnt <= val_cnt + 1;
    mon_prev <= nes_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_read(input logic [7:0] pressed, input logic [7:0] exp_btn,
                         input bit inject, input string tag);
    int cyc, lat0, rise0, val0, gaps;
    bit seen;
    pressed_r = pressed;
    @(negedge clk);
    lat0 = lat_cnt; rise0 = rise_cnt; val0 = val_cnt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen = 1'b0; gaps = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (inject && cyc == 20) start = 1'b1;
      if (!busy) gaps++;
      if (valid) seen = 1'b1;
    end
    check({tag, " valid_seen"}, 32'(seen), 32'd1);
    check({tag, " valid_cycle"}, 32'(cyc), 32'(18 * H + 1));
    check({tag, " buttons"}, 32'(buttons), 32'(exp_btn));
    check({tag, " busy_gaps"}, 32'(gaps), 32'd0);
    if (inject) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " valid_pulse"}, 32'(valid), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " latch_cycles"}, 32'(lat_cnt - lat0), 32'(2 * H));
    check({tag, " clk_rises"}, 32'(rise_cnt - rise0), 32'd8);
    check({tag, " valid_count"}, 32'(val_cnt - val0), 32'd1);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " buttons_hold"}, 32'(buttons), 32'(exp_btn));
  endtask

  task automatic reset_mid_read();
    int val0;
    @(negedge clk);
    val0 = val_cnt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // Cycle 11H+2 lies inside the high phase of bit 4.
    repeat (11 * H + 2) @(negedge clk);
    check("mid_nes_clk_high", 32'(nes_clk), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_nes_clk", 32'(nes_clk), 32'd0);
    check("rst_latch", 32'(nes_latch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_buttons", 32'(buttons), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_valid", 32'(val_cnt - val0), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_latch", 32'(nes_latch), 32'd0);
    check("reset_clk", 32'(nes_clk), 32'd0);
    check("reset_buttons", 32'(buttons), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_read(8'h00, 8'h00, 1'b0, "unplugged");
    do_read(8'h48, DEB ? 8'h00 : 8'h48, 1'b0, "start_left_1");
    do_read(8'h48, 8'h48, 1'b0, "start_left_2");
    do_read(8'hFF, DEB ? 8'h48 : 8'hFF, 1'b0, "all_1");
    do_read(8'hFF, 8'hFF, 1'b0, "all_2");
    do_read(8'h00, DEB ? 8'hFF : 8'h00, 1'b0, "release_1");
    do_read(8'h00, 8'h00, 1'b0, "release_2");
    do_read(8'h48, DEB ? 8'h00 : 8'h48, 1'b0, "pre_inject");
    do_read(8'h48, 8'h48, 1'b1, "inject");
    reset_mid_read();
    do_read(8'h48, DEB ? 8'h00 : 8'h48, 1'b0, "post_rst_1");
    do_read(8'h48, 8'h48, 1'b0, "post_rst_2");
`ifdef NES_RX_DEBOUNCE_EN
    do_read(8'h00, 8'h48, 1'b0, "glitch_pre_1");
    do_read(8'h00, 8'h00, 1'b0, "glitch_pre_2");
    do_read(8'h01, 8'h00, 1'b0, "glitch");
    do_read(8'h00, 8'h00, 1'b0, "glitch_post");
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nes_controller_rx.md
# nes_controller_rx

Serial receiver for a standard NES game controller. Once per frame it drives the controller's latch and clock lines, shifts in the eight button bits, and presents them as a registered, active-high button vector with a one-cycle valid strobe. It replaces the tied-off latch/clock stub and the direct `ui_in` button path at the top level. It is triggered by the sync generator's `frame_end` pulse and feeds the input collector and player logic.

## Interface
- `HALF_PERIOD`, default 151: width of one NES clock half-period in `clk` cycles (about 6 µs at 25.175 MHz). Minimum legal value is 4.
- `clk`  in  1  system pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle read request (`frame_end`). Ignored while `busy`.
- `nes_data`  in  1  controller serial data. Asynchronous; a pressed button reads 0.
- `nes_latch`  out  1  controller latch, active high.
- `nes_clk`  out  1  controller shift clock, idle low.
- `buttons`  out  8  registered button state, 1 = pressed. Bit order: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- `valid`  out  1  one-cycle pulse when a read completes.
- `busy`  out  1  high from the cycle after an accepted `start` until the `valid` cycle, inclusive.

## Operation
- Reset values: `nes_latch`=0, `nes_clk`=0, `buttons`=8'h00, `valid`=0, `busy`=0, state=IDLE, synchroniser flops=1 (released).
- `nes_data` passes through a two-flop synchroniser. All sampling uses the synchronised value.
- A down-counter of width clog2(2·HALF_PERIOD) times every phase. The transition condition for each phase is "counter reaches 0".
- State machine:
  - IDLE: accepts `start`. Moves to LATCH, loads the counter with 2·HALF_PERIOD−1, and sets `nes_latch`=1.
  - LATCH: on expiry, `nes_latch`=0 and the machine moves to CLK_LO with the counter at HALF_PERIOD−1 and bit index=0.
  - CLK_LO: `nes_clk`=0. On expiry, shift register[index] ← ~synchronised `nes_data`, `nes_clk`=1, and the machine moves to CLK_HI.
  - CLK_HI: `nes_clk`=1. On expiry, `nes_clk`=0. If index=7, move to DONE. Otherwise increment the index and return to CLK_LO.
  - DONE: spans exactly one cycle. `buttons` updates (see Configuration), `valid`=1, `busy` drops on the next cycle, and the machine returns to IDLE.
- Exactly 8 `nes_clk` rising edges occur per read. The eighth edge is harmless.
- `start` asserted in any state other than IDLE is dropped. It is not queued.
- `start` arriving on the same cycle as DONE is also dropped. The next `frame_end` retries the read.
- Reset mid-read aborts immediately to reset values. `buttons` returns to 8'h00, and no `valid` is produced.
- An unplugged controller (data line pulled high) reads 8'h00. No error flag is produced.

## Timing
- `start` is seen on cycle 0. `nes_latch` rises on cycle 1 and stays high for 2·HALF_PERIOD cycles.
- Data bit i is sampled at cycle 1 + 2H + 2H·i + H − 1, where H = HALF_PERIOD.
- `valid` and the new `buttons` value both appear at cycle 18·H + 1. With the default H this is 2719 cycles (about 108 µs), well inside one frame.
- `buttons` is stable between `valid` pulses.
- The two-cycle synchroniser delay is absorbed by the H ≥ 4 constraint. The controller's data output is stable for a full half-period before each sample.

## Configuration
- `NES_RX_DEBOUNCE_EN` defined: a shadow register holds the previous raw read (reset 8'h00). In DONE, `buttons` ← raw only when raw equals the shadow, and the shadow ← raw every time. A press is therefore visible only after two identical consecutive reads. `valid` still pulses on every read.
- `NES_RX_DEBOUNCE_EN` undefined: `buttons` ← raw in every DONE, and the shadow register is not instantiated.

## Structure
- Shared package `nes_pkg` contains:
  - the state enum (IDLE, LATCH, CLK_LO, CLK_HI, DONE);
  - button index constants BTN_A … BTN_RIGHT;
  - NES_BITS = 8.
- One sub-module, `nes_input_sync`: a two-flop synchroniser with asynchronous active-low reset to 1. It is reusable for other asynchronous pins.

## Test plan
- Reset release with `nes_data` held at 1, then `start` → `valid` at cycle 18·H+1 and `buttons`=8'h00. `nes_latch` is high for exactly 2H cycles and there are exactly 8 `nes_clk` pulses.
- Controller model that presents A=0 before the first edge and shifts on each `nes_clk` rise, with only Start and Left pressed → `buttons`=8'b0100_1000.
- All buttons pressed → `buttons`=8'hFF. Then all released → 8'h00 on the next read (debounce off), or on the second read (debounce on).
- `start` pulsed mid-read and again on the DONE cycle → both are ignored. Only one `valid` occurs and `busy` is continuous.
- `rst_n` asserted during CLK_HI of bit 4 → `nes_clk`, `nes_latch`, `busy` and `buttons` go to 0 asynchronously. The next `start` performs a full, clean read.
- With `NES_RX_DEBOUNCE_EN`, a single-read glitch 8'h01 between two reads of 8'h00 → `buttons` stays 8'h00 throughout.
